// File: rtl/regfile_dump_reader_pkg.sv
// Shared constants for the regfile dump reader: FSM state encoding and the
// default register-file geometry used by the regfile and CPU top.
package regfile_dump_reader_pkg;

  localparam int RF_DATA_W   = 8;
  localparam int RF_ADDR_W   = 3;
  localparam int RF_NUM_REGS = 8;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] SEND  = 3'd2;
  localparam logic [2:0] CSUM  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

endpackage

// File: rtl/regfile_dump_csum.sv
// XOR accumulator over the register bytes streamed during one scan.
// Clear has priority over enable.
module regfile_dump_csum
  import regfile_dump_reader_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] acc
);

  logic [DATA_W-1:0] acc_d, acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q ^ din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks one regfile read port over registers 0..NUM_REGS-1 and streams each
// byte on a valid/ready interface. REGFILE_DUMP_CSUM_EN appends an XOR beat.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = RF_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [2:0]        state_d, state_q;
  logic [ADDR_W-1:0] idx_d, idx_q;
  logic [ADDR_W-1:0] out_idx_d, out_idx_q;
  logic [DATA_W-1:0] out_data_d, out_data_q;
  logic              out_last_d, out_last_q;
  logic              scan_start;
  logic              beat_acc;

  assign scan_start = (state_q == IDLE) && start;
  assign beat_acc   = (state_q == SEND) && out_ready;

`ifdef REGFILE_DUMP_CSUM_EN
  // csum_phase marks that the beat currently in SEND is the checksum beat.
  logic              csum_phase_d, csum_phase_q;
  logic [DATA_W-1:0] csum_acc;

  regfile_dump_csum #(.DATA_W(DATA_W)) u_csum (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (scan_start),
    .en    (beat_acc && !csum_phase_q),
    .din   (out_data_q),
    .acc   (csum_acc)
  );
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    out_idx_d  = out_idx_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
`ifdef REGFILE_DUMP_CSUM_EN
    csum_phase_d = csum_phase_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          idx_d   = '0;
`ifdef REGFILE_DUMP_CSUM_EN
          csum_phase_d = 1'b0;
`endif
        end
      end
      FETCH: begin
        out_data_d = rd_data;
        out_idx_d  = idx_q;
`ifdef REGFILE_DUMP_CSUM_EN
        out_last_d = 1'b0;
`else
        out_last_d = (idx_q == LAST_IDX);
`endif
        state_d    = SEND;
      end
      SEND: begin
        if (out_ready) begin
`ifdef REGFILE_DUMP_CSUM_EN
          if (csum_phase_q) begin
            state_d      = DONE;
            csum_phase_d = 1'b0;
          end else if (idx_q == LAST_IDX) begin
            state_d = CSUM;
          end else begin
`else
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
`endif
            idx_d   = idx_q + ADDR_W'(1);
            state_d = FETCH;
          end
        end
      end
`ifdef REGFILE_DUMP_CSUM_EN
      // Accumulator already holds the last register byte here.
      CSUM: begin
        out_data_d   = csum_acc;
        out_idx_d    = '0;
        out_last_d   = 1'b1;
        csum_phase_d = 1'b1;
        state_d      = SEND;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      out_idx_q  <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_idx_q  <= out_idx_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end

`ifdef REGFILE_DUMP_CSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_phase_q <= 1'b0;
    else        csum_phase_q <= csum_phase_d;
  end
`endif

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_valid = (state_q == SEND);
  assign rd_addr   = idx_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized bench for regfile_dump_reader: a regfile array drives rd_data and
// expected beats are derived from a snapshot of that array at scan start.
module tb_regfile_dump_reader;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NR = 8;
`ifdef REGFILE_DUMP_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  typedef struct packed {
    logic          l;
    logic [AW-1:0] i;
    logic [DW-1:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n, start, out_ready;
  logic          busy, done, out_valid, out_last;
  logic [AW-1:0] rd_addr, out_idx;
  logic [DW-1:0] rd_data, out_data;
  logic [DW-1:0] rf [NR];
  beat_t         exp_q [$];
  int            n_checks = 0;
  int            n_pass   = 0;

  always #5 clk = ~clk;

  assign rd_data = rf[rd_addr];

  regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_idx"}, out_idx, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_rdaddr"}, rd_addr, 0);
  endtask

  // Expected stream: every register in order, last flag on the final beat,
  // optionally followed by the XOR of all bytes.
  task automatic build_expect();
    logic [DW-1:0] x;
    beat_t b;
    x = '0;
    exp_q.delete();
    for (int i = 0; i < NR; i++) begin
      b.d = rf[i];
      b.i = AW'(i);
      b.l = (i == NR - 1) && !CSUM_ON;
      exp_q.push_back(b);
      x = x ^ rf[i];
    end
    if (CSUM_ON) begin
      b.d = x;
      b.i = '0;
      b.l = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  // ready_mode: 0 always ready, 1 ready one cycle in three, 2 random.
  task automatic run_scan(input string name, input int ready_mode, input bit repulse, input bit wr4);
    int    cyc, dones, done_cyc;
    bit    stalled, wr_now;
    beat_t prev, cur, b;
    build_expect();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; dones = 0; done_cyc = -1; stalled = 1'b0;
    while (cyc < 1000) begin
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = ($urandom_range(99) < 40);
      endcase
      cur = '{l: out_last, i: out_idx, d: out_data};
      if (stalled) begin
        check({name, "_stall_valid"}, out_valid, 1);
        check({name, "_stall_beat"}, cur, prev);
      end
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check({name, "_extra_beat"}, cur, 0);
          end else begin
            b = exp_q.pop_front();
            check({name, "_idx"}, out_idx, b.i);
            check({name, "_data"}, out_data, b.d);
            check({name, "_last"}, out_last, b.l);
          end
        end else begin
          stalled = 1'b1;
          prev    = cur;
        end
      end
      if (repulse && out_valid && out_idx == 3) start = 1'b1;
      wr_now = wr4 && busy && !out_valid && !done && rd_addr == 4;
      @(posedge clk);
      if (wr_now) rf[4] <= 8'hFF;
      #1;
      start = 1'b0;
      cyc++;
      if (done_cyc >= 0 && cyc > done_cyc + 3) break;
    end
    check({name, "_done_count"}, dones, 1);
    check({name, "_beats_left"}, exp_q.size(), 0);
    if (ready_mode == 0) check({name, "_latency"}, done_cyc, 2 * NR + 1 + (CSUM_ON ? 2 : 0));
    check({name, "_idle_after"}, busy, 0);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < NR; i++) rf[i] = DW'(8'h11 * (i + 1));
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_scan("basic", 0, 1'b0, 1'b0);
    run_scan("stall3", 1, 1'b0, 1'b0);
    run_scan("repulse", 0, 1'b1, 1'b0);

    // Reset while the idx 5 beat is being offered.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (!(out_valid && out_idx == 5) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("midrst_reach_idx5", guard < 50, 1);
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("midrst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_stays_idle", busy, 0);
    run_scan("after_rst", 0, 1'b0, 1'b0);

    run_scan("wr4_old", 0, 1'b0, 1'b1);
    check("wr4_applied", rf[4], 8'hFF);
    run_scan("wr4_new", 0, 1'b0, 1'b0);

    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NR; i++) rf[i] = DW'($urandom);
      run_scan("rand", 2, 1'b0, 1'b0);
    end

    // start held high: exactly one IDLE cycle between consecutive scans.
    start = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (!done && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("b2b_first_done", done, 1);
    @(posedge clk); #1;
    check("b2b_idle_gap", busy, 0);
    @(posedge clk); #1;
    check("b2b_restart", busy, 1);
    start = 1'b0;
    guard = 0;
    while (!done && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("b2b_second_done", done, 1);
    @(posedge clk); #1;
    check("b2b_final_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
